fifo_rd_ctrl: RTL

Read-side controller for the asynchronous FIFO, clocked entirely in the clkout domain. It succeeds the fixed 3-bit head/tail comparator and adds several capabilities:
- parametrised depth;
- an extra wrap bit on each pointer, so all 2^ADDR_W entries are usable;
- an internal multi-stage synchroniser for the incoming write pointer;
- a fill-level output and an almost-empty flag.

It drives the read port of the dual-port FIFO memory and returns its Gray read pointer to the write domain.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/ptr_sync.sv | 30 +++
 rtl/fifo_rd_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
// Pointers are handled zero-extended to PTR_W_MAX bits so one function serves every depth.
package fifo_pkg;

   // One spare bit above the widest legal pointer (ADDR_W=10 -> 11 bits).
   localparam int PTR_W_MAX = 12;

   typedef logic [PTR_W_MAX-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t x);
      return x ^ (x >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
      for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module ptr_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   // Stage 0 samples the foreign flop directly; nothing may sit in front of it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: head pointer, empty/level/almost-empty
// decode against the synchronised write pointer, and the Gray head returned to the writer.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AEMPTY_TH   = 1
) (
   input  logic              clkout,
   input  logic              rstout,
   input  logic [ADDR_W:0]   wr_gray_i,
   input  logic              oready,
   output logic              ovalid,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   rd_gray_o,
   output logic [ADDR_W:0]   rd_count,
   output logic              aempty
);

   localparam int PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_TH);

   logic [PTR_W-1:0] head_bin_q, head_bin_d;
   logic [PTR_W-1:0] head_gray_q, head_gray_d;
   logic [PTR_W-1:0] wq, wq_bin, head_inc;
   ptr_t             wq_bin_ext, inc_gray_ext;
   logic             unused_hi;

   ptr_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_wr_sync (
      .clk_i (clkout),
      .rst_i (rstout),
      .d_i   (wr_gray_i),
      .q_o   (wq)
   );

   assign wq_bin_ext   = gray2bin(ptr_t'(wq));
   assign wq_bin       = wq_bin_ext[PTR_W-1:0];
   assign head_inc     = head_bin_q + PTR_W'(1);
   assign inc_gray_ext = bin2gray(ptr_t'(head_inc));
   assign unused_hi    = ^{wq_bin_ext[PTR_W_MAX-1:PTR_W], inc_gray_ext[PTR_W_MAX-1:PTR_W]};

   // Handshake: ovalid is decoded from registers only and never looks at oready; a pop
   // happens on the clkout edge where ovalid && oready, and oready with ovalid low is ignored.
   assign ovalid = (wq != head_gray_q);
   assign rd_en  = ovalid & oready;

   always_comb begin
      head_bin_d  = head_bin_q;
      head_gray_d = head_gray_q;
      if (rd_en) begin
         head_bin_d  = head_inc;
         head_gray_d = inc_gray_ext[PTR_W-1:0];
      end
   end

   always_ff @(posedge clkout or posedge rstout) begin
      if (rstout) begin
         head_bin_q  <= '0;
         head_gray_q <= '0;
      end else begin
         head_bin_q  <= head_bin_d;
         head_gray_q <= head_gray_d;
      end
   end

   // Level can only under-report: wq trails the real write pointer by the sync latency.
   assign rd_count  = wq_bin - head_bin_q;
   assign aempty    = (rd_count <= AEMPTY_LVL);
   assign rd_addr   = head_bin_q[ADDR_W-1:0];
   assign rd_gray_o = head_gray_q;

endmodule
